// File: rtl/ctc_pkg.sv
// Shared definitions for the key scan controller: word length,
// FSM states and the row/column scan maps.
package ctc_pkg;

  localparam logic [5:0] WORD_LAST = 6'd55;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  // Indexed by sys_cnt[2:0]: row drive bit for each slot
  localparam logic [7:0][2:0] ROW_MAP = {
    3'd3, 3'd4, 3'd1, 3'd7,
    3'd6, 3'd5, 3'd2, 3'd0
  };

  // Indexed by sys_cnt[5:3]: column index and whether one is scanned
  localparam logic [7:0][2:0] COL_MAP = {
    3'd0, 3'd4, 3'd3, 3'd0,
    3'd2, 3'd1, 3'd0, 3'd0
  };

  localparam logic [7:0] COL_VLD = 8'b0110_1101;

endpackage

// File: rtl/key_matrix_dec.sv
// Combinational scan decode: sys_cnt to one-hot row drive
// and the column being returned in this slot.
import ctc_pkg::*;

module key_matrix_dec (
  input  logic [5:0] sys_cnt,
  output logic [7:0] kr,
  output logic [2:0] col_sel,
  output logic       col_valid
);

  always_comb begin
    kr = '0;
    kr[ROW_MAP[sys_cnt[2:0]]] = 1'b1;
  end

  assign col_sel   = COL_MAP[sys_cnt[5:3]];
  assign col_valid = COL_VLD[sys_cnt[5:3]];

endmodule

// File: rtl/key_scan_ctl.sv
// Keyboard scan controller with word-based press/release detection.
// Define KSC_DEBOUNCE_EN to build multi-word debounce and release filtering.
import ctc_pkg::*;

module key_scan_ctl #(
  parameter int DEB_WORDS = 3,
  parameter int REL_WORDS = 2
) (
  input  logic       cph2,
  input  logic       nrst,
  input  logic [5:0] sys_cnt,
  input  logic [4:0] kc,
  input  logic       kcode_ack,
  input  logic       stat_clr,
  output logic [7:0] kr,
  output logic [5:0] kcode,
  output logic       kcode_vld,
  output logic       key_stat,
  output logic       key_down
);

  if (DEB_WORDS < 2 || DEB_WORDS > 15 ||
      REL_WORDS < 2 || REL_WORDS > 15) begin : g_bad_param
    $error("key_scan_ctl: DEB_WORDS/REL_WORDS out of range");
  end

  logic [2:0] col_sel;
  logic       col_valid;
  logic [7:0] kc_ext;
  logic       hit;
  logic       word_end;
  logic       word_hit;
  logic [5:0] word_code;
  logic       w_hit;
  logic [5:0] w_code;
  logic       press;
  logic [5:0] press_code;
  state_t     state;
  state_t     state_n;

  key_matrix_dec u_dec (
    .sys_cnt   (sys_cnt),
    .kr        (kr),
    .col_sel   (col_sel),
    .col_valid (col_valid)
  );

  assign kc_ext   = {3'b000, kc};
  assign hit      = col_valid & kc_ext[col_sel];
  assign word_end = (sys_cnt == WORD_LAST);

  // Word result including the sample taken on the word-end edge
  assign w_hit  = word_hit | hit;
  assign w_code = word_hit ? word_code : sys_cnt;

  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      word_hit  <= 1'b0;
      word_code <= '0;
    end else if (word_end) begin
      word_hit  <= 1'b0;
      word_code <= '0;
    end else if (hit && !word_hit) begin
      word_hit  <= 1'b1;
      word_code <= sys_cnt;
    end
  end

`ifdef KSC_DEBOUNCE_EN
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic [3:0] cnt_inc;
  logic [5:0] cand;
  logic [5:0] cand_n;

  assign cnt_inc    = cnt + 4'd1;
  assign press_code = cand;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    press   = 1'b0;
    if (word_end) begin
      unique case (state)
        ST_IDLE: begin
          if (w_hit) begin
            state_n = ST_DEBOUNCE;
            cand_n  = w_code;
            cnt_n   = 4'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!w_hit) begin
            state_n = ST_IDLE;
          end else if (w_code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == 4'(DEB_WORDS)) begin
              state_n = ST_PRESSED;
              press   = 1'b1;
            end
          end else begin
            cand_n = w_code;
            cnt_n  = 4'd1;
          end
        end
        ST_PRESSED: begin
          if (!w_hit) begin
            state_n = ST_RELEASE;
            cnt_n   = 4'd1;
          end
        end
        ST_RELEASE: begin
          if (w_hit) begin
            state_n = ST_PRESSED;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == 4'(REL_WORDS)) state_n = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      cnt  <= '0;
      cand <= '0;
    end else begin
      cnt  <= cnt_n;
      cand <= cand_n;
    end
  end
`else
  assign press_code = w_code;

  always_comb begin
    state_n = state;
    press   = 1'b0;
    if (word_end) begin
      unique case (state)
        ST_IDLE: begin
          if (w_hit) begin
            state_n = ST_PRESSED;
            press   = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!w_hit) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end
`endif

  // A press on the same edge as ack/clear takes priority
  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      kcode     <= '0;
      kcode_vld <= 1'b0;
      key_stat  <= 1'b0;
    end else begin
      state <= state_n;
      if (press) begin
        kcode     <= press_code;
        kcode_vld <= 1'b1;
        key_stat  <= 1'b1;
      end else begin
        if (kcode_ack) kcode_vld <= 1'b0;
        if (stat_clr)  key_stat  <= 1'b0;
      end
    end
  end

  assign key_down = (state == ST_PRESSED) || (state == ST_RELEASE);

endmodule

// File: tb/tb_key_scan_ctl.sv
// Randomized and directed bench for key_scan_ctl against a word-level
// reference model; follows KSC_DEBOUNCE_EN for the expected filtering depth.
module tb_key_scan_ctl;

  localparam int DEB = 3;
  localparam int REL = 2;
`ifdef KSC_DEBOUNCE_EN
  localparam int M_DEB = DEB;
  localparam int M_REL = REL;
`else
  localparam int M_DEB = 1;
  localparam int M_REL = 1;
`endif

  logic       cph2 = 1'b0;
  logic       nrst = 1'b0;
  logic [5:0] sys_cnt = '0;
  logic [4:0] kc = '0;
  logic       kcode_ack = 1'b0;
  logic       stat_clr = 1'b0;
  logic [7:0] kr;
  logic [5:0] kcode;
  logic       kcode_vld;
  logic       key_stat;
  logic       key_down;

  key_scan_ctl #(
    .DEB_WORDS (DEB),
    .REL_WORDS (REL)
  ) dut (
    .cph2      (cph2),
    .nrst      (nrst),
    .sys_cnt   (sys_cnt),
    .kc        (kc),
    .kcode_ack (kcode_ack),
    .stat_clr  (stat_clr),
    .kr        (kr),
    .kcode     (kcode),
    .kcode_vld (kcode_vld),
    .key_stat  (key_stat),
    .key_down  (key_down)
  );

  always #5 cph2 = ~cph2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state (word-level view)
  bit m_down, m_vld, m_stat;
  int m_kcode, run, run_code, miss;
  bit w_hit;
  int w_code;

  function automatic int col_of(input int s);
    case (s / 8)
      0: return 0;
      2: return 1;
      3: return 2;
      5: return 3;
      6: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int row_of(input int s);
    case (s % 8)
      0: return 0;
      1: return 2;
      2: return 5;
      3: return 6;
      4: return 7;
      5: return 1;
      6: return 4;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_down = 0; m_vld = 0; m_stat = 0; m_kcode = 0;
    run = 0; run_code = 0; miss = 0;
    w_hit = 0; w_code = 0;
  endtask

  task automatic word_eval(output bit press);
    press = 0;
    if (!m_down) begin
      if (w_hit) begin
        if (run > 0 && w_code == run_code) run++;
        else begin
          run_code = w_code;
          run = 1;
        end
        if (run >= M_DEB) begin
          m_down = 1; press = 1; m_kcode = w_code;
          run = 0; miss = 0;
        end
      end else run = 0;
    end else begin
      if (w_hit) miss = 0;
      else begin
        miss++;
        if (miss >= M_REL) begin
          m_down = 0; miss = 0; run = 0;
        end
      end
    end
  endtask

  task automatic model_edge(input int s, input logic [4:0] k,
                            input bit ack, input bit clr);
    int c;
    bit h;
    bit press;
    c = col_of(s);
    h = (c >= 0) && k[c];
    press = 0;
    if (s <= 55 && h && !w_hit) begin
      w_hit = 1;
      w_code = s;
    end
    if (s == 55) begin
      word_eval(press);
      w_hit = 0;
      w_code = 0;
    end
    if (press) begin
      m_vld = 1;
      m_stat = 1;
    end else begin
      if (ack) m_vld = 0;
      if (clr) m_stat = 0;
    end
  endtask

  task automatic step(input int s, input logic [4:0] k, input bit ack,
                      input bit clr, input bit rst_now);
    sys_cnt = 6'(s);
    kc = k;
    kcode_ack = ack;
    stat_clr = clr;
    nrst = !rst_now;
    #1;
    check("kr", int'(kr), 1 << row_of(s));
    @(posedge cph2);
    if (rst_now) model_reset();
    else model_edge(s, k, ack, clr);
    #1;
    check("kcode", int'(kcode), m_kcode);
    check("kcode_vld", int'(kcode_vld), int'(m_vld));
    check("key_stat", int'(key_stat), int'(m_stat));
    check("key_down", int'(key_down), int'(m_down));
  endtask

  // mode 0 idle, 1 hold column col, 2 sparse noise
  // noise 0 none, 1 random ack/clr, 2 ack+clr on word end
  task automatic run_word(input int mode, input int col, input int noise,
                          input int rst_at, input int extra);
    logic [4:0] k;
    bit a, c;
    for (int s = 0; s < 56; s++) begin
      case (mode)
        0: k = 5'd0;
        1: k = 5'(1 << col);
        default: k = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      endcase
      a = (noise == 1) ? ($urandom_range(0, 15) == 0) : (noise == 2 && s == 55);
      c = (noise == 1) ? ($urandom_range(0, 15) == 0) : (noise == 2 && s == 55);
      step(s, k, a, c, s == rst_at);
    end
    for (int e = 0; e < extra; e++) step(56 + e, 5'h1f, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    step(0, 5'h1f, 1'b0, 1'b0, 1'b1);
    step(1, 5'h00, 1'b0, 1'b0, 1'b1);

    // Hold column 1 for three words
    for (int w = 0; w < 3; w++) begin
      run_word(1, 1, 0, -1, 0);
      check("hold_down", int'(key_down), int'(w + 1 >= M_DEB));
    end
    check("hold_code", int'(kcode), 16);

    // One empty word then hit again
    run_word(0, 0, 0, -1, 0);
    check("rel1", int'(key_down), int'(M_REL > 1));
    run_word(1, 1, 0, -1, 0);
    check("rehit", int'(key_down), 1);
    for (int w = 0; w < REL; w++) run_word(0, 0, 0, -1, 0);
    check("released", int'(key_down), 0);

    // Two-word burst, gap, three-word burst
    run_word(1, 1, 1, -1, 0);
    run_word(1, 1, 1, -1, 0);
    check("burst2", int'(key_down), int'(M_DEB <= 2));
    for (int w = 0; w < REL; w++) run_word(0, 0, 0, -1, 0);
    for (int w = 0; w < 3; w++) run_word(1, 1, 0, -1, 0);
    check("burst3", int'(kcode), 16);
    for (int w = 0; w < REL; w++) run_word(0, 0, 0, -1, 0);

    // Candidate change: column 0 then column 3
    run_word(1, 0, 0, -1, 4);
    for (int w = 0; w < 3; w++) run_word(1, 3, 0, -1, 0);
    check("restart", int'(kcode), (M_DEB == 1) ? 0 : 40);
    for (int w = 0; w < REL; w++) run_word(0, 0, 0, -1, 0);

    // Ack and stat_clr coinciding with a new press
    for (int w = 0; w < M_DEB - 1; w++) run_word(1, 4, 0, -1, 0);
    run_word(1, 4, 2, -1, 0);
    check("ack_vs_press", int'(kcode_vld), 1);
    check("clr_vs_press", int'(key_stat), 1);
    check("ack_code", int'(kcode), 48);
    for (int w = 0; w < REL; w++) run_word(0, 0, 0, -1, 0);

    // Reset in the middle of a word while filtering
    run_word(1, 2, 0, -1, 0);
    run_word(1, 2, 0, 20, 0);
    for (int w = 0; w < 3; w++) run_word(1, 2, 0, -1, 0);
    check("post_rst", int'(key_down), 1);

    // Randomized bursts
    for (int b = 0; b < 60; b++) begin
      int mode, col, len;
      mode = $urandom_range(0, 2);
      col = $urandom_range(0, 4);
      len = $urandom_range(1, 4);
      for (int w = 0; w < len; w++)
        run_word(mode, col, 1,
                 ($urandom_range(0, 40) == 0) ? int'($urandom_range(0, 55)) : -1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
